// File: rtl/core_dmem_arbiter.sv
// core_dmem_arbiter: shares one core data memory bus between the load/store
// unit (port 0) and a secondary master (port 1). Once a port's request is
// presented it owns the bus until granted or until it abandons the request,
// so address, data and strobe never change under a pending downstream access.
// Request and response paths are purely combinational (zero added latency).
//
// Build option: define CORE_DMEM_ARB_RR_EN for round-robin arbitration via a
// priority pointer; left undefined, port 0 always wins contention in IDLE.
module core_dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                g_clk,
    input  logic                g_resetn,

    input  logic                p0_req,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic                p0_wen,
    input  logic [DATA_W/8-1:0] p0_strb,
    input  logic [DATA_W-1:0]   p0_wdata,
    output logic                p0_gnt,
    output logic                p0_err,
    output logic [DATA_W-1:0]   p0_rdata,

    input  logic                p1_req,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic                p1_wen,
    input  logic [DATA_W/8-1:0] p1_strb,
    input  logic [DATA_W-1:0]   p1_wdata,
    output logic                p1_gnt,
    output logic                p1_err,
    output logic [DATA_W-1:0]   p1_rdata,

    output logic                m_req,
    output logic [ADDR_W-1:0]   m_addr,
    output logic                m_wen,
    output logic [DATA_W/8-1:0] m_strb,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_gnt,
    input  logic                m_err,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t state_s;      // state as seen by the combinational logic
    logic   prio_s;       // favoured port for IDLE contention
    logic   sel_s;        // selected port index
    logic   sel_vld_s;    // a port is selected and driving the bus
    logic   take_s;       // selected access completes this cycle

`ifdef CORE_DMEM_ARB_RR_EN
    logic prio_q;
    logic prio_d;

    // Priority pointer: after a completed access, favour the other port.
    always_comb begin
        prio_d = prio_q;
        if (take_s) begin
            prio_d = ~sel_s;
        end else begin
            prio_d = prio_q;
        end
    end

    // Priority pointer register, cleared by the synchronous reset.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    // While reset is held the pointer behaves as its reset value.
    always_comb begin
        prio_s = 1'b0;
        if (g_resetn) begin
            prio_s = prio_q;
        end else begin
            prio_s = 1'b0;
        end
    end
`else
    // Fixed priority: port 0 always favoured.
    always_comb begin
        prio_s = 1'b0;
    end
`endif

    // While reset is held, outputs follow the IDLE rules regardless of state.
    always_comb begin
        state_s = ST_IDLE;
        if (g_resetn) begin
            state_s = state_q;
        end else begin
            state_s = ST_IDLE;
        end
    end

    // Port selection: arbitrate in IDLE, stay locked to the owner otherwise.
    always_comb begin
        sel_s     = 1'b0;
        sel_vld_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                if (p0_req && p1_req) begin
                    sel_s     = prio_s;
                    sel_vld_s = 1'b1;
                end else if (p1_req) begin
                    sel_s     = 1'b1;
                    sel_vld_s = 1'b1;
                end else if (p0_req) begin
                    sel_s     = 1'b0;
                    sel_vld_s = 1'b1;
                end else begin
                    sel_s     = 1'b0;
                    sel_vld_s = 1'b0;
                end
            end
            ST_OWN0: begin
                // Owner dropping req is an abandon: bus goes quiet at once.
                sel_s     = 1'b0;
                sel_vld_s = p0_req;
            end
            ST_OWN1: begin
                sel_s     = 1'b1;
                sel_vld_s = p1_req;
            end
            default: begin
                sel_s     = 1'b0;
                sel_vld_s = 1'b0;
            end
        endcase
    end

    // A grant only counts when a request is actually on the bus.
    always_comb begin
        take_s = sel_vld_s && m_gnt;
    end

    // Downstream request mux; everything is zero when nothing is selected.
    always_comb begin
        m_req   = 1'b0;
        m_addr  = {ADDR_W{1'b0}};
        m_wen   = 1'b0;
        m_strb  = {STRB_W{1'b0}};
        m_wdata = {DATA_W{1'b0}};
        if (sel_vld_s) begin
            m_req = 1'b1;
            if (sel_s) begin
                m_addr  = p1_addr;
                m_wen   = p1_wen;
                m_strb  = p1_strb;
                m_wdata = p1_wdata;
            end else begin
                m_addr  = p0_addr;
                m_wen   = p0_wen;
                m_strb  = p0_strb;
                m_wdata = p0_wdata;
            end
        end else begin
            m_req = 1'b0;
        end
    end

    // Response routing: gnt/err only to the selected port, rdata broadcast.
    always_comb begin
        p0_gnt   = take_s && !sel_s;
        p1_gnt   = take_s &&  sel_s;
        p0_err   = sel_vld_s && m_err && !sel_s;
        p1_err   = sel_vld_s && m_err &&  sel_s;
        p0_rdata = m_rdata;
        p1_rdata = m_rdata;
    end

    // Ownership next-state: lock an ungranted request, release on grant/abandon.
    always_comb begin
        state_d = state_s;
        case (state_s)
            ST_IDLE: begin
                if (take_s) begin
                    state_d = ST_IDLE;
                end else if (sel_vld_s) begin
                    state_d = sel_s ? ST_OWN1 : ST_OWN0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!sel_vld_s || take_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ownership state register with synchronous active-low reset.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_core_dmem_arbiter.sv
// Directed bench for core_dmem_arbiter. Inputs change on the falling edge and
// outputs are checked 1 ns later, well away from the rising edge. Expected
// values for the arbitration order depend on CORE_DMEM_ARB_RR_EN.
module tb_core_dmem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;

    logic          g_clk;
    logic          g_resetn;
    logic          p0_req, p1_req;
    logic [AW-1:0] p0_addr, p1_addr;
    logic          p0_wen, p1_wen;
    logic [7:0]    p0_strb, p1_strb;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p1_gnt, p0_err, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          m_req, m_wen, m_gnt, m_err;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_strb;
    logic [DW-1:0] m_wdata, m_rdata;

    int total;
    int bad;

`ifdef CORE_DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    core_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_wen(p0_wen), .p0_strb(p0_strb),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_wen(p1_wen), .p1_strb(p1_strb),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .m_req(m_req), .m_addr(m_addr), .m_wen(m_wen), .m_strb(m_strb),
        .m_wdata(m_wdata), .m_gnt(m_gnt), .m_err(m_err), .m_rdata(m_rdata)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_m_req"},   {63'd0, m_req},  64'd0);
        chk({tag, "_m_addr"},  m_addr,          64'd0);
        chk({tag, "_m_wen"},   {63'd0, m_wen},  64'd0);
        chk({tag, "_m_strb"},  {56'd0, m_strb}, 64'd0);
        chk({tag, "_m_wdata"}, m_wdata,         64'd0);
        chk({tag, "_p0_gnt"},  {63'd0, p0_gnt}, 64'd0);
        chk({tag, "_p1_gnt"},  {63'd0, p1_gnt}, 64'd0);
        chk({tag, "_p0_err"},  {63'd0, p0_err}, 64'd0);
        chk({tag, "_p1_err"},  {63'd0, p1_err}, 64'd0);
        chk({tag, "_p0_rdata"}, p0_rdata,       64'd0);
        chk({tag, "_p1_rdata"}, p1_rdata,       64'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        g_resetn = 1'b0;
        p0_req = 1'b0; p0_addr = 64'h1000; p0_wen = 1'b1; p0_strb = 8'hFF;
        p0_wdata = 64'hDEADBEEF_CAFEF00D;
        p1_req = 1'b0; p1_addr = 64'h2000; p1_wen = 1'b0; p1_strb = 8'h0F;
        p1_wdata = 64'h1111_2222_3333_4444;
        m_gnt = 1'b0; m_err = 1'b0; m_rdata = 64'd0;

        // Reset with no requests: every output zero
        @(negedge g_clk);
        @(negedge g_clk); #1;
        chk_quiet("rst");
        g_resetn = 1'b1;

        // Single port write granted in the same cycle
        @(negedge g_clk);
        p0_req = 1'b1; m_gnt = 1'b1; #1;
        chk("sp_m_req",   {63'd0, m_req},  64'd1);
        chk("sp_m_addr",  m_addr,          64'h1000);
        chk("sp_m_wen",   {63'd0, m_wen},  64'd1);
        chk("sp_m_strb",  {56'd0, m_strb}, 64'hFF);
        chk("sp_m_wdata", m_wdata,         64'hDEADBEEF_CAFEF00D);
        chk("sp_p0_gnt",  {63'd0, p0_gnt}, 64'd1);
        chk("sp_p1_gnt",  {63'd0, p1_gnt}, 64'd0);
        // Still IDLE: a lone p1 request is served at once
        @(negedge g_clk);
        p0_req = 1'b0; p1_req = 1'b1; #1;
        chk("sp_idle_m_addr", m_addr,          64'h2000);
        chk("sp_idle_p1_gnt", {63'd0, p1_gnt}, 64'd1);

        // Lock: p0 pending for 3 cycles, then p1 rises, p0 stays on the bus
        @(negedge g_clk);
        p1_req = 1'b0; p0_req = 1'b1; m_gnt = 1'b0; #1;
        chk("lk_c1_m_addr", m_addr,          64'h1000);
        chk("lk_c1_p0_gnt", {63'd0, p0_gnt}, 64'd0);
        @(negedge g_clk); #1;
        chk("lk_c2_m_addr", m_addr, 64'h1000);
        @(negedge g_clk); #1;
        chk("lk_c3_m_addr", m_addr, 64'h1000);
        @(negedge g_clk);
        p1_req = 1'b1; #1;
        chk("lk_p1up_m_addr", m_addr,          64'h1000);
        chk("lk_p1up_m_wen",  {63'd0, m_wen},  64'd1);
        @(negedge g_clk);
        m_gnt = 1'b1; #1;
        chk("lk_gnt_m_addr", m_addr,          64'h1000);
        chk("lk_gnt_p0_gnt", {63'd0, p0_gnt}, 64'd1);
        chk("lk_gnt_p1_gnt", {63'd0, p1_gnt}, 64'd0);
        @(negedge g_clk);
        p0_req = 1'b0; #1;
        chk("lk_next_m_addr", m_addr,          64'h2000);
        chk("lk_next_p1_gnt", {63'd0, p1_gnt}, 64'd1);

        // Reset pulse so arbitration starts from a known pointer
        @(negedge g_clk);
        p1_req = 1'b0; m_gnt = 1'b0; g_resetn = 1'b0;
        @(negedge g_clk);
        g_resetn = 1'b1;

        // Contention: both requests held, granted every cycle
        p0_req = 1'b1; p1_req = 1'b1; m_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic exp1;
            if (i > 0) @(negedge g_clk);
            #1;
            exp1 = RR ? logic'(i % 2) : 1'b0;
            chk($sformatf("arb%0d_p0_gnt", i), {63'd0, p0_gnt}, {63'd0, ~exp1});
            chk($sformatf("arb%0d_p1_gnt", i), {63'd0, p1_gnt}, {63'd0, exp1});
            chk($sformatf("arb%0d_m_addr", i), m_addr, exp1 ? 64'h2000 : 64'h1000);
        end

        // Lone p0 grant (pointer now favours p1 in round-robin)
        @(negedge g_clk);
        p1_req = 1'b0; #1;
        chk("ab_pre_p0_gnt", {63'd0, p0_gnt}, 64'd1);
        // p1 pending without grant: becomes owner
        @(negedge g_clk);
        p0_req = 1'b0; p1_req = 1'b1; m_gnt = 1'b0; #1;
        chk("ab_own_m_req",  {63'd0, m_req}, 64'd1);
        chk("ab_own_m_addr", m_addr,         64'h2000);
        // Owner abandons while p0 asks: bus quiet this cycle
        @(negedge g_clk);
        p1_req = 1'b0; p0_req = 1'b1; #1;
        chk("ab_drop_m_req",  {63'd0, m_req},  64'd0);
        chk("ab_drop_m_addr", m_addr,          64'd0);
        chk("ab_drop_p0_gnt", {63'd0, p0_gnt}, 64'd0);
        // Back in IDLE with pointer unchanged
        @(negedge g_clk);
        p1_req = 1'b1; m_gnt = 1'b1; #1;
        chk("ab_prio_p1_gnt", {63'd0, p1_gnt}, {63'd0, RR});
        chk("ab_prio_p0_gnt", {63'd0, p0_gnt}, {63'd0, ~RR});
        @(negedge g_clk);
        p1_req = 1'b0; #1;
        chk("ab_p0_imm_gnt", {63'd0, p0_gnt}, 64'd1);

        // Error routing on a p1 read
        @(negedge g_clk);
        p0_req = 1'b0; p1_req = 1'b1; m_err = 1'b1; m_rdata = 64'h0123456789ABCDEF; #1;
        chk("er_p1_gnt",   {63'd0, p1_gnt}, 64'd1);
        chk("er_p1_err",   {63'd0, p1_err}, 64'd1);
        chk("er_p0_err",   {63'd0, p0_err}, 64'd0);
        chk("er_m_wen",    {63'd0, m_wen},  64'd0);
        chk("er_p1_rdata", p1_rdata,        64'h0123456789ABCDEF);
        chk("er_p0_rdata", p0_rdata,        64'h0123456789ABCDEF);

        // Stray grant/error with nothing requested is ignored
        @(negedge g_clk);
        p1_req = 1'b0; #1;
        chk("stray_p0_gnt", {63'd0, p0_gnt}, 64'd0);
        chk("stray_p1_gnt", {63'd0, p1_gnt}, 64'd0);
        chk("stray_p0_err", {63'd0, p0_err}, 64'd0);
        chk("stray_p1_err", {63'd0, p1_err}, 64'd0);

        // p0 becomes owner, then reset: IDLE rules apply during reset
        @(negedge g_clk);
        m_gnt = 1'b0; m_err = 1'b0; m_rdata = 64'd0; p0_req = 1'b1; #1;
        chk("rm_own_m_req", {63'd0, m_req}, 64'd1);
        @(negedge g_clk);
        p0_req = 1'b0; p1_req = 1'b1; g_resetn = 1'b0; #1;
        chk("rm_rst_m_req",  {63'd0, m_req}, 64'd1);
        chk("rm_rst_m_addr", m_addr,         64'h2000);
        @(negedge g_clk);
        p1_req = 1'b0; #1;
        chk_quiet("rst2");
        @(negedge g_clk);
        g_resetn = 1'b1; #1;
        chk_quiet("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_dmem_arbiter.md
# core_dmem_arbiter

Shares the single core data memory bus between two requesters: port 0 is the execute-stage load/store unit and port 1 is a secondary master, such as a debug or coprocessor access path. It ownership-locks the bus from the first cycle a request is presented until it is granted, so the downstream memory never sees address, data or strobe change under a pending request. A small state machine tracks ownership. A priority pointer decides contention. The block adds zero cycles of latency to any access.

## Interface
Parameters:
- ADDR_W, default 64, byte address width.
- DATA_W, default 64, data width; strobe width is DATA_W/8.

Ports:
- g_clk  in  1  global clock.
- g_resetn  in  1  reset, synchronous, active-low.
- p0_req / p1_req  in  1  port request; held until the matching gnt.
- p0_addr / p1_addr  in  ADDR_W  double-word-aligned access address.
- p0_wen / p1_wen  in  1  write enable.
- p0_strb / p1_strb  in  DATA_W/8  byte write strobe.
- p0_wdata / p1_wdata  in  DATA_W  write data.
- p0_gnt / p1_gnt  out  1  port access complete.
- p0_err / p1_err  out  1  port access error, valid with gnt.
- p0_rdata / p1_rdata  out  DATA_W  read data, valid with gnt.
- m_req  out  1  downstream request.
- m_addr  out  ADDR_W  downstream address.
- m_wen  out  1  downstream write enable.
- m_strb  out  DATA_W/8  downstream write strobe.
- m_wdata  out  DATA_W  downstream write data.
- m_gnt  in  1  downstream grant; response is in the same cycle.
- m_err  in  1  downstream error.
- m_rdata  in  DATA_W  downstream read data.

## Operation
- Bus protocol on every port: the transaction completes in the cycle where req && gnt. rdata and err are only meaningful in that cycle.
- FSM states: IDLE, OWN0, OWN1. A 1-bit priority pointer `prio` holds the index of the favoured port.
- IDLE, select logic:
  - only one req high: select that port;
  - both high: select port `prio`;
  - neither high: m_req=0.
- IDLE, transitions:
  - selected port x granted in the same cycle (m_gnt=1): stay in IDLE, set prio to the other port (!x);
  - otherwise, if m_req is high: go to OWNx.
- OWNx: the mux is fixed to port x regardless of the other req.
  - m_gnt=1: go to IDLE, set prio to the other port (!x).
  - px_req drops without a grant (abandoned access): go to IDLE, prio unchanged, and m_req falls in the same cycle.
- Mux rules:
  - m_req, m_addr, m_wen, m_strb and m_wdata come from the selected port.
  - All of them are forced to 0 when nothing is selected.
- Response routing:
  - px_gnt = m_gnt && selected==x.
  - px_err = m_err && selected==x.
  - p0_rdata and p1_rdata both carry m_rdata unmodified (broadcast).
- The non-selected port's gnt and err are always 0.
- m_gnt received while m_req=0 is ignored.

## Timing
- Reset: state=IDLE, prio=0.
  - While reset is asserted, all outputs follow the combinational rules from IDLE.
  - With no requests, every output is 0.
- Reset mid-transaction (in OWNx) returns to IDLE next cycle. The requester is responsible for dropping req.
- Zero latency: pX_req→m_req and m_gnt→pX_gnt are combinational paths.
  - Best case: an access completes in the same cycle the request is raised.
- State and prio update on the rising g_clk edge only.
- Back-to-back: a port may re-raise req in the cycle after its gnt. It competes in IDLE with prio already pointing away from it.

## Configuration
- Macro: CORE_DMEM_ARB_RR_EN.
- Defined: round-robin arbitration using `prio` as described.
- Undefined:
  - `prio` register removed;
  - port 0 always wins IDLE contention;
  - ownership lock, abandonment and response routing unchanged. Port 1 can therefore starve under continuous port 0 traffic.

## Test plan
- Single port: p0_req=1, p0_addr=0x1000, p0_wen=1, p0_strb=0xFF, p0_wdata=0xDEADBEEF_CAFEF00D, m_gnt=1 in the same cycle.
  - Required: m_* equals p0 fields, p0_gnt=1, p1_gnt=0, and the state stays IDLE.
- Lock: p0_req held with m_gnt=0 for 3 cycles, then p1_req rises.
  - Required: m_addr stays on p0 until m_gnt, then p0_gnt=1.
  - Required: on the next cycle p1 is selected.
- Round robin (RR_EN defined): both reqs held continuously, m_gnt=1 every cycle.
  - Required: grants alternate p0,p1,p0,p1 starting with p0 after reset.
- Fixed priority (RR_EN undefined): same stimulus as the round-robin case.
  - Required: p0_gnt=1 every cycle, p1_gnt never asserts.
- Abandon: p1 is owner (OWN1) and p1_req drops with m_gnt=0.
  - Required: m_req=0 that cycle, state returns to IDLE, prio unchanged.
  - Required: a following p0 request is served immediately.
- Error routing: p1 read, m_gnt=1, m_err=1, m_rdata=0x0123456789ABCDEF.
  - Required: p1_err=1, p0_err=0, p1_rdata=0x0123456789ABCDEF.
  - Required: reset pulse afterwards returns all outputs to 0 with no requests present.
